// File: rtl/tt_um_toivoh_opbench.sv
// tt_um_toivoh_opbench -- small operation bench.
//
// Operand bytes are loaded into a buffer through a strobed command
// interface. A START snapshots the two halves (x = low, y = high) and
// runs one operation. The result register can then be read one byte at
// a time through a read pointer.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   ena      gates strobe events; a running operation is unaffected
//   ui_in    data byte (operand byte, pointer value or mode)
//   uio_in   [7] strobe, [6:4] command, [3:0] unused
//   uo_out   result byte selected by the read pointer
//   uio_out  [0] busy, [1] done, [7:2] zero
//   uio_oe   constant 8'h0F
module tt_um_toivoh_opbench #(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
    localparam int W         = BYTES_IN * 4;
    localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
    localparam int OW        = BYTES_OUT * 8;
    localparam int SHW       = LOG2_BYTES_IN + 2;   // shift amount width, covers 0..W-1
    localparam int CW        = $clog2(W);

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_SETWP = 3'd1;
    localparam logic [2:0] CMD_START = 3'd2;
    localparam logic [2:0] CMD_SETRP = 3'd3;
    localparam logic [2:0] CMD_NEXT  = 3'd4;

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_ADD  = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_ASR  = 3'd3;
    localparam logic [2:0] MODE_MUL  = 3'd4;

    logic [7:0]                r_buf [BYTES_IN];
    logic [LOG2_BYTES_IN-1:0]  r_wp;
    logic [LOG2_BYTES_OUT-1:0] r_rp;
    logic [2:0]                r_mode;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_stb_q;
    logic [W-1:0]              r_x;      // multiplicand for MUL, shifted left each step
    logic [W-1:0]              r_y;      // multiplier for MUL, shifted right each step
    logic [W-1:0]              r_acc;
    logic [CW-1:0]             r_cnt;
    logic [OW-1:0]             r_result;

    logic                      w_stb;
    logic [2:0]                w_cmd;
    logic [W-1:0]              w_x;
    logic [W-1:0]              w_y;
    logic [W-1:0]              w_mul_sum;
    logic [W:0]                w_res;
    logic [OW+W:0]             w_res_ext;
    logic                      w_store;
    logic                      w_unused;

    // Rising edge of the strobe; history is tracked even while ena is low
    // so a strobe held across ena rising does not fire late.
    assign w_stb = uio_in[7] & ~r_stb_q & ena;
    assign w_cmd = uio_in[6:4];

    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < BYTES_IN / 2; i++) begin
            w_x[i*8 +: 8] = r_buf[i];
            w_y[i*8 +: 8] = r_buf[i + BYTES_IN/2];
        end
    end

    // One shift-add step; the final step's sum is the stored product.
    assign w_mul_sum = r_acc + (r_y[0] ? r_x : '0);

    always_comb begin
        w_res = '0;
        case (r_mode)
            MODE_PASS: w_res = {1'b0, r_x};
            MODE_ADD:  w_res = {1'b0, r_x} + {1'b0, r_y};
            MODE_NAND: w_res = {1'b0, ~(r_x & r_y)};
            MODE_ASR:  w_res = {1'b0, $unsigned($signed(r_x) >>> r_y[SHW-1:0])};
            MODE_MUL:  w_res = {1'b0, w_mul_sum};
            default:   w_res = '0;
        endcase
    end

    // Padding then taking the low OW bits gives zero-extend or truncate
    // for any W/OW combination.
    assign w_res_ext = {{OW{1'b0}}, w_res};

    assign w_store = r_busy & ((r_mode != MODE_MUL) | (r_cnt == CW'(W - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BYTES_IN; i++) r_buf[i] <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_mode   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_stb_q  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_stb_q <= uio_in[7];

            if (r_busy) begin
                if (r_mode == MODE_MUL) begin
                    r_acc <= w_mul_sum;
                    r_x   <= r_x << 1;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_store) begin
                    r_result <= w_res_ext[OW-1:0];
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end

            // START is only taken while idle, so it never collides with
            // the busy-path updates above.
            if (w_stb) begin
                case (w_cmd)
                    CMD_WRITE: begin
                        r_buf[r_wp] <= ui_in;
                        r_wp        <= r_wp + 1'b1;
                    end
                    CMD_SETWP: r_wp <= ui_in[LOG2_BYTES_IN-1:0];
                    CMD_START: begin
                        if (!r_busy) begin
                            r_mode <= ui_in[2:0];
                            r_x    <= w_x;
                            r_y    <= w_y;
                            r_acc  <= '0;
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                            r_done <= 1'b0;
                        end
                    end
                    CMD_SETRP: r_rp <= ui_in[LOG2_BYTES_OUT-1:0];
                    CMD_NEXT:  r_rp <= r_rp + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign uo_out   = r_result[{r_rp, 3'b000} +: 8];
    assign uio_out  = {6'b0, r_done, r_busy};
    assign uio_oe   = 8'h0F;

    assign w_unused = &{1'b0, uio_in[3:0]};

endmodule

// File: tb/tb_tt_um_toivoh_opbench.sv
// Self-checking bench for tt_um_toivoh_opbench (default parameters:
// 32-bit x/y operands, 32-bit result). Expected results are queued when
// a START is issued and popped when the result is read back.
module tb_tt_um_toivoh_opbench;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk = 0;
    int n_err = 0;
    int busy_cyc = 0;
    logic [31:0] sb[$];

    tt_um_toivoh_opbench dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Busy as seen at each rising edge.
    always @(posedge clk) if (uio_out[0]) busy_cyc <= busy_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        logic [63:0] p;
        case (m)
            3'd0: return x;
            3'd1: begin s = {1'b0, x} + {1'b0, y}; return s[31:0]; end
            3'd2: return ~(x & y);
            3'd3: return $unsigned($signed(x) >>> y[4:0]);
            3'd4: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    // One strobed command; called and returns at a falling edge.
    task automatic cmd(input logic [2:0] c, input logic [7:0] d);
        uio_in = {1'b1, c, 4'b0};
        ui_in  = d;
        @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] v;
        v = {y, x};
        cmd(3'd1, 8'h00);
        for (int i = 0; i < 8; i++) cmd(3'd0, v[i*8 +: 8]);
    endtask

    task automatic read_result(output logic [31:0] r);
        cmd(3'd3, 8'h00);
        r[7:0] = uo_out;
        for (int i = 1; i < 4; i++) begin
            cmd(3'd4, 8'h00);
            r[i*8 +: 8] = uo_out;
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!uio_out[1] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, {31'b0, uio_out[1]}, 32'h1);
    endtask

    task automatic check_result(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        read_result(r);
        e = sb.pop_front();
        chk(tag, r, e);
    endtask

    task automatic run(input logic [2:0] m, input logic [31:0] exp, input string tag);
        int b0;
        b0 = busy_cyc;
        sb.push_back(exp);
        cmd(3'd2, {5'b0, m});
        wait_done(tag);
        chk({tag, "_busy_cycles"}, busy_cyc - b0, (m == 3'd4) ? 32 : 1);
        check_result(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        int b0;

        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_uo_out", {24'b0, uo_out}, 32'h0);
        chk("rst_uio_out", {24'b0, uio_out}, 32'h0);
        chk("uio_oe", {24'b0, uio_oe}, 32'h0F);

        // Bytes 01..08, PASS, then a 9th write wraps onto byte 0.
        load(32'h04030201, 32'h08070605);
        run(3'd0, 32'h04030201, "pass_seq");
        cmd(3'd0, 8'hAA);
        run(3'd0, 32'h040302AA, "wp_wrap");

        load(32'h12345678, 32'h00000009);
        run(3'd5, 32'h00000000, "mode5_zero");

        load(32'hFFFFFFFF, 32'h00000001);
        run(3'd1, 32'h00000000, "add_carry_trunc");
        load(32'h12345678, 32'h11111111);
        run(3'd1, model(3'd1, 32'h12345678, 32'h11111111), "add_plain");

        load(32'hFFFFFFFF, 32'hFFFFFFFF);
        run(3'd2, 32'h00000000, "nand_ones");
        load(32'h0F0F00FF, 32'h00FF0F0F);
        run(3'd2, model(3'd2, 32'h0F0F00FF, 32'h00FF0F0F), "nand_mix");

        load(32'h80000000, 32'h00000004);
        run(3'd3, 32'hF8000000, "asr_neg");

        // MUL with an ignored START and a buffer WRITE while busy.
        // rd_ptr is 3 from the last read, so uo_out shows F8 until the store.
        load(32'h00010000, 32'h00010001);
        b0 = busy_cyc;
        sb.push_back(32'h00010000);
        cmd(3'd2, 8'h04);
        chk("mul_busy", {31'b0, uio_out[0]}, 32'h1);
        chk("mul_done_clr", {31'b0, uio_out[1]}, 32'h0);
        chk("mul_hold_prev", {24'b0, uo_out}, 32'hF8);
        cmd(3'd2, 8'h00);
        cmd(3'd0, 8'hFF);
        chk("mul_hold_prev2", {24'b0, uo_out}, 32'hF8);
        wait_done("mul");
        chk("mul_busy_cycles", busy_cyc - b0, 32);
        check_result("mul");
        run(3'd0, 32'h000100FF, "write_in_busy");

        rx = $urandom;
        ry = $urandom;
        load(rx, ry);
        run(3'd4, model(3'd4, rx, ry), "mul_rand");
        load(rx, ry);
        run(3'd3, model(3'd3, rx, ry), "asr_rand");

        // Held strobe writes once; a strobe with ena low does nothing.
        load(32'h11223344, 32'h00000000);
        cmd(3'd1, 8'h00);
        uio_in = {1'b1, 3'd0, 4'b0};
        ui_in  = 8'h55;
        repeat (5) @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
        cmd(3'd0, 8'h66);
        ena = 1'b0;
        cmd(3'd0, 8'h77);
        ena = 1'b1;
        run(3'd0, 32'h11226655, "held_strobe_ena");

        // Reset during MUL, with a same-cycle WRITE strobe.
        load(32'h00010000, 32'h00010001);
        cmd(3'd2, 8'h04);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        uio_in = {1'b1, 3'd0, 4'b0};
        ui_in  = 8'hEE;
        @(negedge clk);
        chk("abort_busy", {31'b0, uio_out[0]}, 32'h0);
        chk("abort_done", {31'b0, uio_out[1]}, 32'h0);
        chk("abort_uo_out", {24'b0, uo_out}, 32'h0);
        rst = 1'b0;
        uio_in = 8'h00;
        @(negedge clk);
        cmd(3'd0, 8'hA1);
        cmd(3'd0, 8'hA2);
        cmd(3'd0, 8'hA3);
        cmd(3'd0, 8'hA4);
        sb.push_back(32'hA4A3A2A1);
        cmd(3'd2, 8'h00);
        wait_done("post_rst");
        chk("post_rst_rp0", {24'b0, uo_out}, 32'hA1);
        check_result("post_rst_wp0");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
